// File: rtl/pipeline_ctrl_pkg.sv
// Shared control definitions for the ID-stage hazard and stall logic.
package pipeline_ctrl_pkg;

    // Stall sequencer states; ST_FLUSH_WAIT is a reserved encoding only.
    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_STALL1     = 2'd1,
        ST_FLUSH_WAIT = 2'd2
    } ctrl_state_t;

    // Major opcodes decoded by the hazard detector.
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

endpackage

// File: rtl/pipeline_stall_ctrl_sat.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Clear wins over increment; increment stops at the all-ones value.
    always_ff @(posedge clk) begin
        if (clr)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage core: turns hazard and mispredict
// indications into PC/IF-ID enables, the ID-EX bubble and the IF-ID flush.
module pipeline_stall_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int WARM_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_stall,
    input  logic [1:0]        br_stall,
    input  logic              mispredict,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic [WARM_W-1:0] warmup_cnt,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    ctrl_state_t state_q;
    ctrl_state_t state_d;

    // State register; reset abandons any owed stall cycle.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

    // Next state and control outputs; mispredict outranks every stall.
    always_comb begin
        state_d     = state_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        busy        = 1'b0;
        if (rst) begin
            state_d = ST_RUN;
        end else if (mispredict) begin
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            busy        = (state_q != ST_RUN);
            state_d     = ST_RUN;
        end else begin
            busy = (state_q != ST_RUN);
            case (state_q)
                ST_RUN: begin
                    if (br_stall[1]) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                        state_d     = ST_STALL1;
                    end else if (load_stall || br_stall[0]) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                ST_STALL1: begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                    state_d     = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Cycles since reset or last redirect, gating the hazard detector.
    sat_counter #(.W(WARM_W)) u_warmup (
        .clk (clk),
        .clr (rst | mispredict),
        .inc (1'b1),
        .cnt (warmup_cnt)
    );

    // Wrapping performance counters; a reset cycle never counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_en)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (mispredict)
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Randomised and directed checks of pipeline_stall_ctrl against a
// cycle-level model built from outstanding-stall bookkeeping.
module tb_pipeline_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_stall;
    logic [1:0]  br_stall;
    logic        mispredict;

    logic        pc_en, ifid_en, idex_bubble, ifid_flush, busy;
    logic [2:0]  warmup_cnt;
    logic [31:0] stall_cycles, flush_count;

    logic        pc_en4, ifid_en4, idex_bubble4, ifid_flush4, busy4;
    logic [2:0]  warmup_cnt4;
    logic [3:0]  stall_cycles4, flush_count4;

    always #5 clk = ~clk;

    pipeline_stall_ctrl u_dut (
        .clk(clk), .rst(rst), .load_stall(load_stall), .br_stall(br_stall),
        .mispredict(mispredict), .pc_en(pc_en), .ifid_en(ifid_en),
        .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
        .warmup_cnt(warmup_cnt), .busy(busy),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    pipeline_stall_ctrl #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .load_stall(load_stall), .br_stall(br_stall),
        .mispredict(mispredict), .pc_en(pc_en4), .ifid_en(ifid_en4),
        .idex_bubble(idex_bubble4), .ifid_flush(ifid_flush4),
        .warmup_cnt(warmup_cnt4), .busy(busy4),
        .stall_cycles(stall_cycles4), .flush_count(flush_count4)
    );

    typedef struct {
        logic        pc_en;
        logic        ifid_en;
        logic        bubble;
        logic        flush;
        logic        busy;
        int unsigned warm;
        int unsigned stalls;
        int unsigned flushes;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Model: number of stall cycles still owed, plus plain counters.
    int          owed;
    int unsigned m_warm, m_stalls, m_flushes;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    // Drive one cycle, push the expected response, then advance the model.
    task automatic cyc(input logic r, input logic ld, input logic [1:0] b, input logic m);
        exp_t e;
        int   need;
        @(posedge clk);
        #1;
        rst = r; load_stall = ld; br_stall = b; mispredict = m;
        e.pc_en = 1'b1; e.ifid_en = 1'b1; e.bubble = 1'b0; e.flush = 1'b0;
        e.busy = 1'b0;
        e.warm = m_warm; e.stalls = m_stalls; e.flushes = m_flushes;
        if (r) begin
            owed = 0; m_warm = 0; m_stalls = 0; m_flushes = 0;
        end else if (m) begin
            e.ifid_en = 1'b0; e.flush = 1'b1; e.bubble = 1'b1;
            e.busy = (owed > 0);
            owed = 0; m_warm = 0; m_flushes++;
        end else begin
            if (owed > 0) begin
                e.busy = 1'b1;
                need = owed;
            end else begin
                need = b[1] ? 2 : ((ld || b[0]) ? 1 : 0);
            end
            if (need > 0) begin
                e.pc_en = 1'b0; e.ifid_en = 1'b0; e.bubble = 1'b1;
                m_stalls++;
                owed = need - 1;
            end
            if (m_warm < 7) m_warm++;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: compare every presented cycle against the oldest expectation.
    initial begin
        exp_t e;
        logic [31:0] s4, f4;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                s4 = 32'(e.stalls % 16);
                f4 = 32'(e.flushes % 16);
                chk("pc_en",        32'(pc_en),        32'(e.pc_en));
                chk("ifid_en",      32'(ifid_en),      32'(e.ifid_en));
                chk("idex_bubble",  32'(idex_bubble),  32'(e.bubble));
                chk("ifid_flush",   32'(ifid_flush),   32'(e.flush));
                chk("busy",         32'(busy),         32'(e.busy));
                chk("warmup_cnt",   32'(warmup_cnt),   e.warm);
                chk("stall_cycles", stall_cycles,      e.stalls);
                chk("flush_count",  flush_count,       e.flushes);
                chk("stall_cycles_w4", 32'(stall_cycles4), s4);
                chk("flush_count_w4",  32'(flush_count4),  f4);
                chk("pc_en_w4",     32'(pc_en4),       32'(e.pc_en));
            end
        end
    end

    initial begin
        int wait_cyc;
        rst = 1'b1; load_stall = 1'b0; br_stall = 2'b00; mispredict = 1'b0;
        owed = 0; m_warm = 0; m_stalls = 0; m_flushes = 0;
        repeat (2) @(posedge clk);

        // Reset state, then warm-up ramp and saturation.
        cyc(1, 0, 2'b00, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 2'b00, 0);
        // Single-cycle load-use stall.
        cyc(0, 1, 2'b00, 0);
        cyc(0, 0, 2'b00, 0);
        cyc(0, 0, 2'b00, 0);
        // Two-cycle load-to-branch stall.
        cyc(0, 0, 2'b10, 0);
        cyc(0, 0, 2'b00, 0);
        cyc(0, 0, 2'b00, 0);
        // Mispredict aborting STALL1.
        cyc(1, 0, 2'b00, 0);
        cyc(0, 0, 2'b10, 0);
        cyc(0, 0, 2'b00, 1);
        cyc(0, 0, 2'b00, 0);
        // Mispredict together with a load stall, and with reset.
        cyc(0, 1, 2'b00, 1);
        cyc(0, 0, 2'b00, 0);
        cyc(1, 1, 2'b11, 1);
        cyc(0, 1, 2'b10, 0);
        cyc(0, 0, 2'b00, 0);
        // Wrap of the 4-bit stall counter.
        cyc(1, 0, 2'b00, 0);
        for (int i = 0; i < 18; i++) cyc(0, 0, 2'b01, 0);
        // Reset in the middle of STALL1.
        cyc(0, 0, 2'b10, 0);
        cyc(1, 0, 2'b00, 0);
        cyc(0, 0, 2'b00, 0);
        cyc(0, 0, 2'b00, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic r, ld, m;
            logic [1:0] b;
            r  = ($urandom_range(0, 63) == 0);
            m  = ($urandom_range(0, 7) == 0);
            ld = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            cyc(r, ld, b, m);
        end

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Sequences pipeline stalls and flushes for the 5-stage core.
- Consumes the hazard detector's load_stall and br_stall[1:0] and the EX-stage branch-mispredict signal.
- Drives PC/IF-ID write enables, the ID-EX bubble and the IF-ID flush.
- Owns the post-redirect warm-up counter that gates the hazard detector. Sits beside the hazard detector in the ID stage.

Parameters:
- CNT_W, 32, width of the performance counters (stall_cycles, flush_count).
- WARM_W, 3, width of warmup_cnt; saturates at all-ones.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- load_stall  input  1  load-use hazard from hazard detector
- br_stall  input  2  [0]: ALU result feeds branch in ID; [1]: load result feeds branch in ID
- mispredict  input  1  EX-stage branch resolved against prediction; redirect this cycle
- pc_en  output  1  PC register write enable
- ifid_en  output  1  IF/ID register write enable
- idex_bubble  output  1  force NOP (control bits zero) into ID/EX
- ifid_flush  output  1  clear IF/ID to NOP
- warmup_cnt  output  WARM_W  cycles since reset/last redirect, saturating; feeds hazard detector pcsrc_counter
- busy  output  1  FSM not in RUN
- stall_cycles  output  CNT_W  count of cycles with pc_en=0, wraps
- flush_count  output  CNT_W  count of mispredict flushes, wraps

Behaviour:
- Reset (rst=1 at edge): state=RUN, warmup_cnt=0, stall_cycles=0, flush_count=0.
- Control outputs are combinational from state and inputs. During a rst cycle they read as RUN with no hazard: pc_en=1, ifid_en=1, idex_bubble=0, ifid_flush=0, busy=0.
- States: RUN, STALL1 (one more stall cycle owed), FLUSH_WAIT (unused encoding reserved; never entered). Two live states.
- Stall requirement from inputs (RUN only):
  - br_stall[1] -> 2 cycles
  - else load_stall or br_stall[0] -> 1 cycle
  - else 0 cycles
- RUN, no hazard, no mispredict: pc_en=1, ifid_en=1, idex_bubble=0, ifid_flush=0; stay RUN.
- RUN, 1-cycle hazard: same cycle pc_en=0, ifid_en=0, idex_bubble=1; stay RUN. The hazard detector re-evaluates next cycle and normally deasserts.
- RUN, 2-cycle hazard: same cycle stall outputs as above; next state STALL1.
- STALL1: pc_en=0, ifid_en=0, idex_bubble=1, busy=1. Hazard inputs ignored. Next state RUN.
- mispredict (any state) has priority over every stall:
  - pc_en=1, ifid_en=0, ifid_flush=1, idex_bubble=1
  - next state RUN (aborts STALL1)
  - warmup_cnt <= 0 at the edge
  - flush_count += 1
- warmup_cnt: increments by 1 each non-reset, non-mispredict cycle; holds at 2^WARM_W-1. Stalls do not freeze it.
- stall_cycles: +1 on every non-reset cycle where pc_en=0. Wraps modulo 2^CNT_W with no flag.
- Simultaneous load_stall and br_stall[1]: 2 cycles (max wins). Simultaneous rst and mispredict: rst wins, counters not incremented.
- rst asserted while in STALL1: next state RUN; stall abandoned.

Decomposition:
- Shared package (pipeline_ctrl_pkg):
  - state encoding localparams ST_RUN, ST_STALL1
  - opcode constants (OP_B etc.) already used by the hazard detector
- One natural sub-module, sat_counter (parameterised width, sync clear, saturating increment), used for warmup_cnt.
- Perf counters stay inline (wrapping increments).

Test Plan:
- rst high 2 cycles, then low, no hazards -> warmup_cnt reads 0,1,2,...,7,7; pc_en=1 throughout; stall_cycles=0.
- load_stall=1 for one cycle in RUN -> that cycle pc_en=0, ifid_en=0, idex_bubble=1; next cycle pc_en=1; stall_cycles=1; busy never 1.
- br_stall=2'b10 one cycle -> two consecutive cycles pc_en=0 with idex_bubble=1; busy=1 on the second; state back to RUN; stall_cycles=2.
- br_stall=2'b10 then mispredict=1 on the STALL1 cycle -> that cycle pc_en=1, ifid_flush=1, idex_bubble=1; next cycle RUN, warmup_cnt=0; flush_count=1; stall_cycles=1.
- load_stall=1 and mispredict=1 same cycle -> pc_en=1, ifid_flush=1, no stall counted; warmup_cnt=0 next cycle.
- Preload-equivalent: run 2^CNT_W stall cycles with CNT_W overridden to 4 -> stall_cycles wraps 15->0; rst mid-STALL1 -> next cycle RUN, all counters 0.
